// File: rtl/qspi_boot_seq.sv
// Power-up sequencer owning the shared QSPI pads: wakes PSRAM and flash in 1-bit SPI, then hands the pads to the core.
// Optional `QSPI_BOOT_QPI_EN adds a final 0x35 command that puts the PSRAM into QPI mode.
module qspi_boot_seq #(
    parameter int unsigned LOCK_DLY_W    = 8,
    parameter int unsigned CMD_GAP       = 4,
    parameter int unsigned POST_RST_WAIT = 16,
    parameter logic [7:0]  RAM_RSTEN     = 8'h66,
    parameter logic [7:0]  RAM_RST       = 8'h99,
    parameter logic [7:0]  ROM_WAKE      = 8'hAB
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       locked_i,
    input  logic       core_cs_ram_on,
    input  logic       core_cs_rom_on,
    input  logic       core_sck_i,
    input  logic [3:0] core_sd_i,
    input  logic [3:0] core_sdoen_i,
    output logic       mem_cs_ram_on,
    output logic       mem_cs_rom_on,
    output logic       mem_sck_o,
    output logic [3:0] mem_sd_o,
    output logic [3:0] mem_sdoen_o,
    output logic       core_rst_no,
    output logic       done_o
);

    localparam logic [7:0] RAM_QPI = 8'h35;
`ifdef QSPI_BOOT_QPI_EN
    localparam logic [1:0] LAST_CMD = 2'd3;
`else
    localparam logic [1:0] LAST_CMD = 2'd2;
`endif

    localparam int unsigned CNT_W0 = (LOCK_DLY_W > 5) ? LOCK_DLY_W : 5;
    localparam int unsigned CNT_W1 = ($clog2(CMD_GAP + 1) > CNT_W0) ? $clog2(CMD_GAP + 1) : CNT_W0;
    localparam int unsigned CNT_W  = ($clog2(POST_RST_WAIT + 1) > CNT_W1) ?
                                     $clog2(POST_RST_WAIT + 1) : CNT_W1;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((1 << LOCK_DLY_W) - 2);
    localparam logic [CNT_W-1:0] FRAME_LAST  = CNT_W'(16);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(CMD_GAP - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(POST_RST_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CMD,
        GAP,
        WAIT,
        RUN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       cmd_idx;
    logic             lock_meta;
    logic             lock_sync;
    logic             cs_ram_q;
    logic             cs_rom_q;
    logic             sck_q;
    logic             sd0_q;
    logic             sdoen0_q;
    logic [4:0]       k_next;
    logic [1:0]       idx_next;
    logic             run_mode;

    function automatic logic [7:0] cmd_op(input logic [1:0] idx);
        case (idx)
            2'd0:    return RAM_RSTEN;
            2'd1:    return RAM_RST;
            2'd2:    return ROM_WAKE;
            default: return RAM_QPI;
        endcase
    endfunction

    function automatic logic cmd_is_rom(input logic [1:0] idx);
        return (idx == 2'd2);
    endfunction

    function automatic logic frame_sck(input logic [4:0] k);
        return ~k[4] & k[0];
    endfunction

    // Bit index advances on even k, so data only moves while sck is low.
    function automatic logic frame_sd(input logic [7:0] op, input logic [4:0] k);
        return ~k[4] & op[3'd7 - k[3:1]];
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign k_next   = cnt[4:0] + 5'd1;
    assign idx_next = cmd_idx + 2'd1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= locked_i;
            lock_sync <= lock_meta;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            cmd_idx     <= 2'd0;
            cs_ram_q    <= 1'b1;
            cs_rom_q    <= 1'b1;
            sck_q       <= 1'b0;
            sd0_q       <= 1'b0;
            sdoen0_q    <= 1'b0;
            core_rst_no <= 1'b0;
            done_o      <= 1'b0;
        end else if (!lock_sync && state != IDLE) begin
            // Lock lost: abort any frame with CS high and fall back to reset conditions.
            state       <= IDLE;
            cnt         <= '0;
            cmd_idx     <= 2'd0;
            cs_ram_q    <= 1'b1;
            cs_rom_q    <= 1'b1;
            sck_q       <= 1'b0;
            sd0_q       <= 1'b0;
            sdoen0_q    <= 1'b0;
            core_rst_no <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (lock_sync) begin
                        state <= SETTLE;
                        cnt   <= '0;
                    end
                end
                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state    <= CMD;
                        cnt      <= '0;
                        cmd_idx  <= 2'd0;
                        cs_ram_q <= cmd_is_rom(2'd0);
                        cs_rom_q <= ~cmd_is_rom(2'd0);
                        sck_q    <= 1'b0;
                        sd0_q    <= frame_sd(cmd_op(2'd0), 5'd0);
                        sdoen0_q <= 1'b1;
                    end else begin
                        cnt <= cnt_inc(cnt);
                    end
                end
                CMD: begin
                    if (cnt == FRAME_LAST) begin
                        state    <= (cmd_idx == LAST_CMD) ? WAIT : GAP;
                        cnt      <= '0;
                        cs_ram_q <= 1'b1;
                        cs_rom_q <= 1'b1;
                        sck_q    <= 1'b0;
                        sd0_q    <= 1'b0;
                        sdoen0_q <= 1'b0;
                    end else begin
                        cnt   <= cnt_inc(cnt);
                        sck_q <= frame_sck(k_next);
                        sd0_q <= frame_sd(cmd_op(cmd_idx), k_next);
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state    <= CMD;
                        cnt      <= '0;
                        cmd_idx  <= idx_next;
                        cs_ram_q <= cmd_is_rom(idx_next);
                        cs_rom_q <= ~cmd_is_rom(idx_next);
                        sck_q    <= 1'b0;
                        sd0_q    <= frame_sd(cmd_op(idx_next), 5'd0);
                        sdoen0_q <= 1'b1;
                    end else begin
                        cnt <= cnt_inc(cnt);
                    end
                end
                WAIT: begin
                    if (cnt == WAIT_LAST) begin
                        state       <= RUN;
                        cnt         <= '0;
                        core_rst_no <= 1'b1;
                        done_o      <= 1'b1;
                    end else begin
                        cnt <= cnt_inc(cnt);
                    end
                end
                RUN: begin
                    cnt <= '0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // In RUN the core owns the pads with no added latency.
    assign run_mode      = (state == RUN);
    assign mem_cs_ram_on = run_mode ? core_cs_ram_on : cs_ram_q;
    assign mem_cs_rom_on = run_mode ? core_cs_rom_on : cs_rom_q;
    assign mem_sck_o     = run_mode ? core_sck_i     : sck_q;
    assign mem_sd_o      = run_mode ? core_sd_i      : {3'b000, sd0_q};
    assign mem_sdoen_o   = run_mode ? core_sdoen_i   : {3'b000, sdoen0_q};

endmodule

// File: tb/tb_qspi_boot_seq.sv
// Bench for qspi_boot_seq: decodes the SPI frames seen on the pads and checks them against the expected boot timeline.
module tb_qspi_boot_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       locked;
    logic       core_cs_ram_on;
    logic       core_cs_rom_on;
    logic       core_sck;
    logic [3:0] core_sd;
    logic [3:0] core_sdoen;
    logic       mem_cs_ram_on;
    logic       mem_cs_rom_on;
    logic       mem_sck_o;
    logic [3:0] mem_sd_o;
    logic [3:0] mem_sdoen_o;
    logic       core_rst_no;
    logic       done_o;

    int checks = 0;
    int errors = 0;

`ifdef QSPI_BOOT_QPI_EN
    localparam int NCMD = 4;
`else
    localparam int NCMD = 3;
`endif
    localparam int SETTLE     = 255;
    localparam int GAP        = 4;
    localparam int WAITC      = 16;
    localparam int FRAME      = 17;
    localparam int SYNC_EDGES = 2;
    // Edges counted from the first edge after locked is raised.
    localparam int FIRST_FALL = SYNC_EDGES + 1 + SETTLE;
    localparam int RUN_EDGE   = FIRST_FALL + NCMD * FRAME + (NCMD - 1) * GAP + WAITC;

    always #5 clk = ~clk;

    qspi_boot_seq dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .locked_i      (locked),
        .core_cs_ram_on(core_cs_ram_on),
        .core_cs_rom_on(core_cs_rom_on),
        .core_sck_i    (core_sck),
        .core_sd_i     (core_sd),
        .core_sdoen_i  (core_sdoen),
        .mem_cs_ram_on (mem_cs_ram_on),
        .mem_cs_rom_on (mem_cs_rom_on),
        .mem_sck_o     (mem_sck_o),
        .mem_sd_o      (mem_sd_o),
        .mem_sdoen_o   (mem_sdoen_o),
        .core_rst_no   (core_rst_no),
        .done_o        (done_o)
    );

    function automatic logic [7:0] exp_op(input int i);
        case (i)
            0:       return 8'h66;
            1:       return 8'h99;
            2:       return 8'hAB;
            default: return 8'h35;
        endcase
    endfunction

    function automatic logic [10:0] pads();
        return {mem_cs_ram_on, mem_cs_rom_on, mem_sck_o, mem_sd_o, mem_sdoen_o};
    endfunction

    localparam logic [10:0] PADS_IDLE = 11'b110_0000_0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_core();
        core_cs_ram_on = 1'($urandom);
        core_cs_rom_on = 1'($urandom);
        core_sck       = 1'($urandom);
        core_sd        = 4'($urandom);
        core_sdoen     = 4'($urandom);
    endtask

    // Called right after locked is raised; follows the boot to RUN while the core drives noise.
    task automatic boot_check(input string tag);
        int e = 0;
        int nwin = 0;
        int wlen = 0;
        int rises = 0;
        int gapc = 0;
        int first_fall = -1;
        int bad_idle = 0;
        int bad_frame = 0;
        int bad_ctrl = 0;
        logic in_win = 1'b0;
        logic win_rom = 1'b0;
        logic prev_sck = 1'b0;
        logic prev_sd = 1'b0;
        logic seen_run = 1'b0;
        logic [7:0] sh = 8'h00;
        logic [7:0] got_op [4];
        logic       got_rom [4];
        int         got_rises [4];
        int         got_len [4];
        for (int i = 0; i < 4; i++) begin
            got_op[i] = 8'h00; got_rom[i] = 1'b0; got_rises[i] = 0; got_len[i] = 0;
        end
        while (!seen_run && e < 3000) begin
            rand_core();
            step();
            e++;
            if (core_rst_no === 1'b1) begin
                seen_run = 1'b1;
            end else begin
                if (done_o !== 1'b0) bad_ctrl++;
                if (!in_win) begin
                    if (mem_cs_ram_on === 1'b0 || mem_cs_rom_on === 1'b0) begin
                        if (nwin == 0) first_fall = e;
                        else chk($sformatf("%s gap%0d", tag, nwin), 32'(gapc), 32'(GAP));
                        in_win  = 1'b1;
                        win_rom = (mem_cs_rom_on === 1'b0);
                        wlen    = 1;
                        rises   = 0;
                        sh      = 8'h00;
                        if ({mem_cs_ram_on, mem_cs_rom_on} !== (win_rom ? 2'b10 : 2'b01)) bad_frame++;
                        if (mem_sck_o !== 1'b0 || mem_sdoen_o !== 4'b0001 || mem_sd_o[3:1] !== 3'b000) bad_frame++;
                        prev_sck = mem_sck_o;
                        prev_sd  = mem_sd_o[0];
                    end else begin
                        gapc++;
                        if (pads() !== PADS_IDLE) bad_idle++;
                    end
                end else if (mem_cs_ram_on === 1'b1 && mem_cs_rom_on === 1'b1) begin
                    if (nwin < 4) begin
                        got_op[nwin] = sh; got_rom[nwin] = win_rom;
                        got_rises[nwin] = rises; got_len[nwin] = wlen;
                    end
                    nwin++;
                    in_win = 1'b0;
                    gapc   = 1;
                    if (pads() !== PADS_IDLE) bad_idle++;
                end else begin
                    wlen++;
                    if ({mem_cs_ram_on, mem_cs_rom_on} !== (win_rom ? 2'b10 : 2'b01)) bad_frame++;
                    if (mem_sdoen_o !== 4'b0001 || mem_sd_o[3:1] !== 3'b000) bad_frame++;
                    if (mem_sck_o === 1'b1 && prev_sck === 1'b0) begin
                        sh = {sh[6:0], mem_sd_o[0]};
                        rises++;
                    end
                    if (mem_sck_o === 1'b1 && mem_sd_o[0] !== prev_sd) bad_frame++;
                    prev_sck = mem_sck_o;
                    prev_sd  = mem_sd_o[0];
                end
            end
        end
        chk($sformatf("%s run_edge", tag), 32'(e), 32'(RUN_EDGE));
        chk($sformatf("%s first_cs_fall", tag), 32'(first_fall), 32'(FIRST_FALL));
        chk($sformatf("%s frames", tag), 32'(nwin), 32'(NCMD));
        for (int i = 0; i < NCMD; i++) begin
            chk($sformatf("%s op%0d", tag, i), 32'(got_op[i]), 32'(exp_op(i)));
            chk($sformatf("%s rom_cs%0d", tag, i), 32'(got_rom[i]), 32'(i == 2));
            chk($sformatf("%s rises%0d", tag, i), 32'(got_rises[i]), 32'd8);
            chk($sformatf("%s cs_low_len%0d", tag, i), 32'(got_len[i]), 32'(FRAME));
        end
        chk($sformatf("%s wait", tag), 32'(gapc), 32'(WAITC));
        chk($sformatf("%s idle_pads", tag), 32'(bad_idle), 32'd0);
        chk($sformatf("%s frame_shape", tag), 32'(bad_frame), 32'd0);
        chk($sformatf("%s done_early", tag), 32'(bad_ctrl), 32'd0);
        chk($sformatf("%s done_in_run", tag), 32'(done_o), 32'd1);
    endtask

    initial begin
        int e;
        int nwin;
        int wlen;
        int lows;
        logic in_win;
        logic found;
        logic cs_low;
        logic [10:0] drv;

        rst = 1'b1;
        locked = 1'b0;
        rand_core();
        repeat (3) step();
        chk("reset pads", 32'(pads()), 32'(PADS_IDLE));
        chk("reset core_rst_no", 32'(core_rst_no), 32'd0);
        chk("reset done", 32'(done_o), 32'd0);

        rst = 1'b0;
        repeat (5) begin rand_core(); step(); end
        chk("idle no lock pads", 32'(pads()), 32'(PADS_IDLE));
        chk("idle no lock core_rst_no", 32'(core_rst_no), 32'd0);

        locked = 1'b1;
        boot_check("boot1");

        // Core owns the pads in RUN, same cycle.
        core_cs_ram_on = 1'b1; core_cs_rom_on = 1'b0; core_sck = 1'b1;
        core_sd = 4'hA; core_sdoen = 4'hF;
        #1;
        chk("handover directed", 32'(pads()), 32'({1'b1, 1'b0, 1'b1, 4'hA, 4'hF}));
        for (int i = 0; i < 8; i++) begin
            rand_core();
            drv = {core_cs_ram_on, core_cs_rom_on, core_sck, core_sd, core_sdoen};
            #1;
            chk($sformatf("handover rand%0d", i), 32'(pads()), 32'(drv));
            step();
            chk($sformatf("handover hold%0d", i), 32'(pads()), 32'(drv));
        end

        // Lock loss while in RUN.
        locked = 1'b0;
        repeat (3) begin rand_core(); step(); end
        chk("run unlock pads", 32'(pads()), 32'(PADS_IDLE));
        chk("run unlock core_rst_no", 32'(core_rst_no), 32'd0);
        chk("run unlock done", 32'(done_o), 32'd0);

        // Relock and drop lock at k=7 of the second frame.
        locked = 1'b1;
        e = 0; nwin = 0; wlen = 0; in_win = 1'b0; found = 1'b0;
        while (!found && e < 3000) begin
            rand_core();
            step();
            e++;
            cs_low = !(mem_cs_ram_on === 1'b1 && mem_cs_rom_on === 1'b1);
            if (cs_low && !in_win) begin
                in_win = 1'b1; wlen = 1; nwin++;
            end else if (cs_low) begin
                wlen++;
            end else begin
                in_win = 1'b0;
            end
            if (in_win && nwin == 2 && wlen == 8) found = 1'b1;
        end
        chk("drop point reached", 32'(found), 32'd1);
        chk("drop frame on ram", 32'({mem_cs_ram_on, mem_cs_rom_on}), 32'(2'b01));
        locked = 1'b0;
        repeat (3) begin rand_core(); step(); end
        chk("abort pads", 32'(pads()), 32'(PADS_IDLE));
        chk("abort core_rst_no", 32'(core_rst_no), 32'd0);
        lows = 0;
        repeat (20) begin
            rand_core();
            step();
            if (pads() !== PADS_IDLE || core_rst_no !== 1'b0) lows++;
        end
        chk("unlocked stays idle", 32'(lows), 32'd0);

        locked = 1'b1;
        boot_check("reboot");

        // Random drop during SETTLE.
        locked = 1'b0;
        repeat (5) step();
        locked = 1'b1;
        repeat ($urandom_range(5, 200)) begin rand_core(); step(); end
        locked = 1'b0;
        repeat (3) begin rand_core(); step(); end
        lows = 0;
        repeat (300) begin
            rand_core();
            step();
            if (pads() !== PADS_IDLE || core_rst_no !== 1'b0 || done_o !== 1'b0) lows++;
        end
        chk("settle unlock idle", 32'(lows), 32'd0);

        locked = 1'b1;
        boot_check("boot3");

        // Asynchronous reset in RUN between edges.
        core_cs_ram_on = 1'b0; core_cs_rom_on = 1'b0; core_sck = 1'b1;
        core_sd = 4'hF; core_sdoen = 4'hF;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async rst pads", 32'(pads()), 32'(PADS_IDLE));
        chk("async rst core_rst_no", 32'(core_rst_no), 32'd0);
        chk("async rst done", 32'(done_o), 32'd0);
        #2;
        rst = 1'b0;
        boot_check("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
